alu_uart_frontend: RTL and testbench

Sequencing front end that drives the combinational ALU's operand and opcode inputs from a byte stream and returns its result. It sits between a UART receiver/transmitter pair and the ALU. It collects three received bytes (operand A, operand B, opcode) and holds them on the ALU inputs. It then captures the ALU result and hands it to the transmitter as one byte, using a start/done handshake.

---
 rtl/alu_uart_frontend_pkg.sv | 35 +++
 rtl/alu_uart_frontend.sv | 129 ++++++++++++
 tb/tb_alu_uart_frontend.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_frontend_pkg.sv
// Shared definitions for the ALU byte-stream front end: FSM state encoding
// and the ALU opcode constants used by both this block and the ALU.
package alu_uart_frontend_pkg;

   localparam int NB_STATE = 3;

   localparam logic [NB_STATE-1:0] ST_WAIT_A    = 3'd0;
   localparam logic [NB_STATE-1:0] ST_WAIT_B    = 3'd1;
   localparam logic [NB_STATE-1:0] ST_WAIT_OP   = 3'd2;
   localparam logic [NB_STATE-1:0] ST_EXEC      = 3'd3;
   localparam logic [NB_STATE-1:0] ST_SEND      = 3'd4;
   localparam logic [NB_STATE-1:0] ST_WAIT_DONE = 3'd5;

   typedef enum logic [NB_STATE-1:0] {
      WAIT_A    = ST_WAIT_A,
      WAIT_B    = ST_WAIT_B,
      WAIT_OP   = ST_WAIT_OP,
      EXEC      = ST_EXEC,
      SEND      = ST_SEND,
      WAIT_DONE = ST_WAIT_DONE
   } state_t;

   localparam int NB_OPCODE = 6;

   localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;

   // States in which a received byte has nowhere to go and must be dropped.
   function automatic logic is_busy(input state_t s);
      return (s == EXEC) || (s == SEND) || (s == WAIT_DONE);
   endfunction

endpackage

// File: rtl/alu_uart_frontend.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// holds them on the ALU inputs, then hands the ALU result to the transmitter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_A    | idle, next received byte is operand A
// WAIT_B    | next received byte is operand B
// WAIT_OP   | next received byte carries the opcode in its low bits
// EXEC      | ALU inputs stable, capture ALU result
// SEND      | pulse o_tx_start for one cycle
// WAIT_DONE | transmitter busy, wait for i_tx_done
module alu_uart_frontend
   import alu_uart_frontend_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [NB_DATA-1:0]        i_rx_data,
   input  logic                      i_rx_valid,
   output logic signed [NB_DATA-1:0] o_data_a,
   output logic signed [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]          o_operation_code,
   input  logic signed [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0]        o_tx_data,
   output logic                      o_tx_start,
   input  logic                      i_tx_done,
   output logic                      o_rx_drop
);

   state_t state;
   state_t state_next;

   logic signed [NB_DATA-1:0] data_a_q;
   logic signed [NB_DATA-1:0] data_b_q;
   logic [NB_OP-1:0]          opcode_q;
   logic [NB_DATA-1:0]        result_q;
   logic                      rx_drop_q;

   logic ld_a;
   logic ld_b;
   logic ld_op;
   logic ld_res;
   logic tx_start;
   logic drop_next;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= WAIT_A;
         data_a_q  <= '0;
         data_b_q  <= '0;
         opcode_q  <= '0;
         result_q  <= '0;
         rx_drop_q <= 1'b0;
      end else begin
         state     <= state_next;
         rx_drop_q <= drop_next;
         if (ld_a) begin
            data_a_q <= i_rx_data;
         end
         if (ld_b) begin
            data_b_q <= i_rx_data;
         end
         if (ld_op) begin
            opcode_q <= i_rx_data[NB_OP-1:0];
         end
         if (ld_res) begin
            result_q <= i_alu_result;
         end
      end
   end

   always_comb begin
      state_next = state;
      ld_a       = 1'b0;
      ld_b       = 1'b0;
      ld_op      = 1'b0;
      ld_res     = 1'b0;
      tx_start   = 1'b0;
      drop_next  = i_rx_valid && is_busy(state);

      case (state)
         WAIT_A: begin
            if (i_rx_valid) begin
               ld_a       = 1'b1;
               state_next = WAIT_B;
            end
         end
         WAIT_B: begin
            if (i_rx_valid) begin
               ld_b       = 1'b1;
               state_next = WAIT_OP;
            end
         end
         WAIT_OP: begin
            if (i_rx_valid) begin
               ld_op      = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            ld_res     = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            // i_tx_done here belongs to no transmission of ours; ignore it.
            tx_start   = 1'b1;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               state_next = WAIT_A;
            end
         end
         default: begin
            state_next = WAIT_A;
         end
      endcase
   end

   assign o_data_a         = data_a_q;
   assign o_data_b         = data_b_q;
   assign o_operation_code = opcode_q;
   assign o_tx_data        = result_q;
   assign o_tx_start       = tx_start;
   assign o_rx_drop        = rx_drop_q;

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Directed bench for alu_uart_frontend with a behavioural ALU closing the loop.
module tb_alu_uart_frontend;
   import alu_uart_frontend_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic signed [7:0] data_a;
   logic signed [7:0] data_b;
   logic [5:0]        opcode;
   logic signed [7:0] alu_result;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_done;
   logic              rx_drop;

   int checks   = 0;
   int failures = 0;
   int n_start  = 0;
   int n_drop   = 0;

   always #5 clk = ~clk;

   alu_uart_frontend #(.NB_DATA(8), .NB_OP(6)) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_rx_data        (rx_data),
      .i_rx_valid       (rx_valid),
      .o_data_a         (data_a),
      .o_data_b         (data_b),
      .o_operation_code (opcode),
      .i_alu_result     (alu_result),
      .o_tx_data        (tx_data),
      .o_tx_start       (tx_start),
      .i_tx_done        (tx_done),
      .o_rx_drop        (rx_drop)
   );

   always_comb begin
      alu_result = '0;
      case (opcode)
         OP_ADD:  alu_result = data_a + data_b;
         OP_SUB:  alu_result = data_a - data_b;
         OP_AND:  alu_result = data_a & data_b;
         OP_OR:   alu_result = data_a | data_b;
         default: alu_result = '0;
      endcase
   end

   always @(posedge clk) begin
      if (tx_start === 1'b1) n_start++;
      if (rx_drop === 1'b1) n_drop++;
   end

   // Sends A, B, opcode back to back and checks the EXEC/SEND timing.
   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [5:0] exp_op, input logic [7:0] exp_tx,
                            input bit done_at_start, input string name);
      int s0;
      s0 = n_start;
      @(negedge clk); rx_data = a;   rx_valid = 1'b1;
      @(negedge clk); rx_data = b;
      @(negedge clk); rx_data = opb;
      @(negedge clk); rx_valid = 1'b0;
      checks++;
      if (data_a !== a) begin
         failures++; $display("FAIL %s data_a got=%h exp=%h", name, data_a, a);
      end
      checks++;
      if (data_b !== b) begin
         failures++; $display("FAIL %s data_b got=%h exp=%h", name, data_b, b);
      end
      checks++;
      if (opcode !== exp_op) begin
         failures++; $display("FAIL %s opcode got=%h exp=%h", name, opcode, exp_op);
      end
      checks++;
      if (tx_start !== 1'b0) begin
         failures++; $display("FAIL %s tx_start_exec got=%b exp=0", name, tx_start);
      end
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b1) begin
         failures++; $display("FAIL %s tx_start_send got=%b exp=1", name, tx_start);
      end
      checks++;
      if (tx_data !== exp_tx) begin
         failures++; $display("FAIL %s tx_data got=%h exp=%h", name, tx_data, exp_tx);
      end
      if (done_at_start) tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (tx_start !== 1'b0) begin
         failures++; $display("FAIL %s tx_start_after got=%b exp=0", name, tx_start);
      end
      checks++;
      if (n_start - s0 != 1) begin
         failures++; $display("FAIL %s start_pulses got=%0d exp=1", name, n_start - s0);
      end
   endtask

   task automatic finish_tx();
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
   endtask

   // One byte while busy: must be dropped with a single registered pulse.
   task automatic send_drop(input logic [7:0] x, input logic [7:0] exp_a, input bit with_done,
                            input string name);
      int d0;
      d0 = n_drop;
      @(negedge clk); rx_data = x; rx_valid = 1'b1; tx_done = with_done;
      @(negedge clk); rx_valid = 1'b0; tx_done = 1'b0;
      checks++;
      if (rx_drop !== 1'b1) begin
         failures++; $display("FAIL %s rx_drop got=%b exp=1", name, rx_drop);
      end
      checks++;
      if (data_a !== exp_a) begin
         failures++; $display("FAIL %s data_a_kept got=%h exp=%h", name, data_a, exp_a);
      end
      @(negedge clk);
      checks++;
      if (rx_drop !== 1'b0 || n_drop - d0 != 1) begin
         failures++;
         $display("FAIL %s drop_once got=%b/%0d exp=0/1", name, rx_drop, n_drop - d0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({data_a, data_b, opcode, tx_data} !== 30'd0) begin
         failures++;
         $display("FAIL reset regs got=%h/%h/%h/%h exp=0", data_a, data_b, opcode, tx_data);
      end
      checks++;
      if (tx_start !== 1'b0 || rx_drop !== 1'b0) begin
         failures++; $display("FAIL reset pulses got=%b/%b exp=0/0", tx_start, rx_drop);
      end
   endtask

   task automatic test_add();
      run_frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 1'b0, "add");
      finish_tx();
   endtask

   task automatic test_sub();
      run_frame(8'h03, 8'h05, 8'hE2, 6'h22, 8'hFE, 1'b0, "sub");
      finish_tx();
   endtask

   task automatic test_unsupported();
      run_frame(8'h07, 8'h02, 8'h3F, 6'h3F, 8'h00, 1'b0, "unsup");
      finish_tx();
   endtask

   task automatic test_mid_reset();
      @(negedge clk); rx_data = 8'h11; rx_valid = 1'b1;
      @(negedge clk); rx_data = 8'h22;
      @(negedge clk); rx_valid = 1'b0; reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      checks++;
      if ({data_a, data_b, opcode, tx_data} !== 30'd0) begin
         failures++;
         $display("FAIL midreset regs got=%h/%h/%h/%h exp=0", data_a, data_b, opcode, tx_data);
      end
      run_frame(8'h01, 8'h01, 8'h20, 6'h20, 8'h02, 1'b0, "after_reset");
      finish_tx();
   endtask

   task automatic test_drop();
      int s0;
      run_frame(8'h04, 8'h04, 8'h20, 6'h20, 8'h08, 1'b0, "drop_frame");
      s0 = n_start;
      repeat (10) @(negedge clk);
      send_drop(8'h09, 8'h04, 1'b0, "drop_wait_done");
      repeat (8) @(negedge clk);
      checks++;
      if (n_start != s0 || tx_data !== 8'h08) begin
         failures++; $display("FAIL hold_off extra_starts=%0d tx_data=%h exp=0/08", n_start - s0, tx_data);
      end
      finish_tx();
      run_frame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1'b0, "after_drop");
      finish_tx();
   endtask

   task automatic test_done_with_start();
      run_frame(8'h0A, 8'h03, 8'h24, 6'h24, 8'h02, 1'b1, "done_at_start");
      send_drop(8'h55, 8'h0A, 1'b0, "still_wait_done");
      finish_tx();
      run_frame(8'h0C, 8'h03, 8'h25, 6'h25, 8'h0F, 1'b0, "after_done_ign");
   endtask

   task automatic test_back_to_back();
      // FSM is in WAIT_DONE from the previous task; byte arrives with done.
      send_drop(8'h77, 8'h0C, 1'b1, "rx_with_done");
      run_frame(8'h80, 8'h01, 8'h22, 6'h22, 8'h7F, 1'b0, "b2b_sub");
      finish_tx();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_unsupported();
      test_mid_reset();
      test_drop();
      test_done_with_start();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
